// File: rtl/bus_arbiter.sv
// bus_arbiter: four-master round-robin bus arbiter with registered active-low grants and parking.
// Optional per-owner hold limit under contention is enabled by defining BUS_ARB_TIMEOUT_EN.
module bus_arbiter #(
    parameter int MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       m0_req_n,
    input  logic       m1_req_n,
    input  logic       m2_req_n,
    input  logic       m3_req_n,
    output logic       m0_grnt_n,
    output logic       m1_grnt_n,
    output logic       m2_grnt_n,
    output logic       m3_grnt_n,
    output logic [1:0] bus_owner
);
    typedef enum logic [1:0] {OWNER_M0, OWNER_M1, OWNER_M2, OWNER_M3} owner_t;

    owner_t     owner, next_owner, search_owner;
    logic [3:0] req, grnt_n;
    logic       keep;

    if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_max_hold
        $error("bus_arbiter: MAX_HOLD must be within 1..255");
    end

    assign req = ~{m3_req_n, m2_req_n, m1_req_n, m0_req_n};
    assign {m3_grnt_n, m2_grnt_n, m1_grnt_n, m0_grnt_n} = grnt_n;
    assign bus_owner = owner;

`ifdef BUS_ARB_TIMEOUT_EN
    logic [7:0] hold_cnt;
    logic       others;
    logic       timed_out;
    assign others    = |(req & ~(4'b0001 << owner));
    assign timed_out = others && (hold_cnt == 8'(MAX_HOLD - 1));
    assign keep      = req[owner] && !timed_out;
`else
    assign keep = req[owner];
`endif

    // rotational search from owner+1; walking downward leaves the nearest requester, or the owner when idle
    always_comb begin
        search_owner = owner;
        for (int i = 3; i >= 1; i--)
            if (req[2'(owner + i)]) search_owner = owner_t'(2'(owner + i));
        next_owner = keep ? owner : search_owner;
    end

    // owner, grants and hold counter advance together so grants always match bus_owner
    always_ff @(posedge clk) begin
        if (!reset) begin
            owner    <= OWNER_M0;
            grnt_n   <= 4'b1110;
`ifdef BUS_ARB_TIMEOUT_EN
            hold_cnt <= 8'd0;
`endif
        end else begin
            owner    <= next_owner;
            grnt_n   <= ~(4'b0001 << next_owner);
`ifdef BUS_ARB_TIMEOUT_EN
            hold_cnt <= (next_owner != owner || !others) ? 8'd0 :
                        (hold_cnt == 8'hff) ? hold_cnt : hold_cnt + 8'd1;
`endif
        end
    end
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed checks of reset, rotation, parking, skip, hold limit and mid-run reset.
module tb_bus_arbiter;
    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] rn;
    logic       m0_grnt_n, m1_grnt_n, m2_grnt_n, m3_grnt_n;
    logic [1:0] bus_owner;
    int         tests = 0;
    int         fails = 0;

    bus_arbiter #(.MAX_HOLD(4)) dut (
        .clk(clk),
        .reset(reset),
        .m0_req_n(rn[0]),
        .m1_req_n(rn[1]),
        .m2_req_n(rn[2]),
        .m3_req_n(rn[3]),
        .m0_grnt_n(m0_grnt_n),
        .m1_grnt_n(m1_grnt_n),
        .m2_grnt_n(m2_grnt_n),
        .m3_grnt_n(m3_grnt_n),
        .bus_owner(bus_owner)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [5:0] got, input logic [5:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: grants/owner got %b expected %b", tag, got, exp);
        end
    endtask

    function automatic logic [5:0] exp_of(input int o);
        logic [3:0] g;
        g = ~(4'b0001 << o);
        return {g, 2'(o)};
    endfunction

    task automatic expect_owner(input string tag, input int o);
        check(tag, {m3_grnt_n, m2_grnt_n, m1_grnt_n, m0_grnt_n, bus_owner}, exp_of(o));
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        rn    = 4'b0000;
        step(2);
        expect_owner("reset", 0);
        reset = 1'b1;
        rn    = 4'b1110;
        for (int i = 0; i < 3; i++) begin
            step(1);
            expect_owner("hold_m0", 0);
        end
        rn = 4'b0000;
        for (int o = 0; o < 4; o++) begin
            step(2);
            expect_owner("rot_hold", o);
            rn[o] = 1'b1;
            step(1);
            expect_owner("rot_handoff", (o + 1) % 4);
            rn[o] = 1'b0;
        end
        rn = 4'b1011;
        step(1);
        expect_owner("park_get_m2", 2);
        rn = 4'b1111;
        step(1);
        expect_owner("park_1", 2);
        step(3);
        expect_owner("park_4", 2);
        rn = 4'b1101;
        step(1);
        expect_owner("park_wake_m1", 1);
        rn = 4'b0111;
        step(1);
        expect_owner("get_m3", 3);
        rn = 4'b1001;
        step(1);
        expect_owner("skip_m0", 1);
        rn = 4'b1011;
        step(1);
        expect_owner("skip_m2", 2);
        rn = 4'b0110;
        step(1);
        expect_owner("nearest_m3", 3);
        rn = 4'b1110;
        step(1);
        expect_owner("get_m0", 0);
        rn = 4'b1100;
`ifdef BUS_ARB_TIMEOUT_EN
        for (int i = 0; i < 3; i++) begin
            step(1);
            expect_owner("to_hold", 0);
        end
        step(1);
        expect_owner("to_handoff_m1", 1);
        rn = 4'b1110;
        step(1);
        expect_owner("to_return_m0", 0);
`else
        step(4);
        expect_owner("nto_hold4", 0);
        step(100);
        expect_owner("nto_hold104", 0);
        rn = 4'b1101;
        step(1);
        expect_owner("nto_release_m1", 1);
`endif
        rn = 4'b1101;
        step(1);
        expect_owner("pre_reset_m1", 1);
        reset = 1'b0;
        step(1);
        expect_owner("reset_mid", 0);
        reset = 1'b1;
        rn = 4'b1111;
        step(1);
        expect_owner("post_reset_park", 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Round-robin arbiter for the four-master shared bus. It samples the active-low bus requests of masters 0–3 and drives exactly one active-low grant at all times. The bus master multiplexer uses these grants to route the granted master's address, strobe, read/write and write data onto the shared bus. Grants are registered; the bus is parked on the last owner when nobody requests.

## Interface
Parameters:
- MAX_HOLD, 16: maximum consecutive cycles one owner keeps the bus while another master is waiting; legal range 1..255; used only when BUS_ARB_TIMEOUT_EN is defined.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  reset; synchronous, active-low.
- m0_req_n  input  1  master 0 bus request, active-low.
- m1_req_n  input  1  master 1 bus request, active-low.
- m2_req_n  input  1  master 2 bus request, active-low.
- m3_req_n  input  1  master 3 bus request, active-low.
- m0_grnt_n  output  1  master 0 grant, active-low, registered.
- m1_grnt_n  output  1  master 1 grant, active-low, registered.
- m2_grnt_n  output  1  master 2 grant, active-low, registered.
- m3_grnt_n  output  1  master 3 grant, active-low, registered.
- bus_owner  output  2  index of the current owner, registered; always consistent with the grants.

## Operation
- State: `owner` register (2 bits, encodes OWNER_M0..OWNER_M3) and `hold_cnt` (8 bits, present only with the macro).
- Outputs decode from `owner`: the grant for index `owner` is 0, the other three grants are 1. Exactly one grant is low at every cycle, including idle.
- Next-owner rule, evaluated every cycle:
  - If the current owner's request is low and it has not timed out, `owner` is unchanged.
  - Otherwise search owner+1, owner+2, owner+3 (mod 4). The first index with its request low becomes the new owner.
  - If no other master requests, `owner` is unchanged (parking). This holds whether or not the owner still requests.
- Priority is purely rotational, with no fixed priority. A waiting master is granted within 3 ownership changes.
- Reset (reset=0 at a rising edge): owner=0, so m0_grnt_n=0, m1..m3_grnt_n=1, bus_owner=0; hold_cnt=0. Reset mid-transfer overrides any owner and takes effect at that edge.

## Timing
- Latency: a request change seen at edge N affects the grants after edge N (visible in cycle N+1).
  - Handoff: the owner deasserts its request in cycle k; the new grant is valid from cycle k+1. No cycle has zero grants or two grants.
  - Request to a parked bus: a request asserted in cycle k is granted from cycle k+1. If the requester is already the parked owner, the grant is already low (0-cycle wait).
- Simultaneous events:
  - The owner releases while several others request: the lowest rotational distance from the owner wins.
  - The owner releases and re-requests in the same sampled cycle: treated as still requesting, so it retains ownership.
- Requests are level-sensitive. A master must hold its request low until it has finished using the bus.

## Configuration
- BUS_ARB_TIMEOUT_EN defined:
  - hold_cnt increments each cycle the owner keeps the bus while requesting and at least one other request is low; it saturates at 255.
  - hold_cnt clears to 0 on any ownership change, and when no other master requests.
  - When hold_cnt == MAX_HOLD-1 and another request is low, the owner is treated as not requesting. The next edge hands off by the normal rotational search, so the owner holds for exactly MAX_HOLD cycles under contention.
  - A preempted master that still requests is re-queued rotationally.
- BUS_ARB_TIMEOUT_EN undefined:
  - No hold_cnt and no MAX_HOLD logic.
  - The owner keeps the bus indefinitely while its request is low.

## Test plan
- Reset: hold reset=0 for 2 cycles with all requests low → m0_grnt_n=0, m1..m3_grnt_n=1, bus_owner=0. After release, m0 keeps the grant while m0_req_n=0.
- Rotation: all four requests low; each owner drops its request after 3 cycles then re-requests → grant order 0,1,2,3,0. Each handoff occurs exactly 1 cycle after the drop.
- Parking: master 2 owns the bus and releases, no other requests → bus_owner stays 2, m2_grnt_n stays 0. Then m1_req_n=0 → m1 is granted the next cycle.
- Skip: owner=3 releases while only m1 and m2 request → m0 is skipped and m1 is granted. After m1 releases, m2 is granted.
- Timeout (macro defined, MAX_HOLD=4): m0 holds its request low permanently, m1 requests from cycle 0 → m0 holds for exactly 4 cycles, then m1 is granted. When m1 releases, the grant returns to m0.
- No timeout (macro undefined): same stimulus → m0 keeps the grant for 100+ cycles; m1 is granted 1 cycle after m0 releases.
